// File: rtl/msdf_otf_converter_pkg.sv
// Shared definitions for the MSDF serial-digit path: the signed-digit
// encoding (also used by the multiplier datapath) and the converter FSM states.
package msdf_otf_converter_pkg;

  // Two-bit signed-digit encoding: bit 1 = positive, bit 0 = negative.
  localparam logic [1:0] DIGIT_POS  = 2'b10;
  localparam logic [1:0] DIGIT_NEG  = 2'b01;
  localparam logic [1:0] DIGIT_ZERO = 2'b00;

  // Converter word-assembly states.
  typedef enum logic {
    IDLE = 1'b0,  // no digit of the current word consumed yet
    ACC  = 1'b1   // 1..N-1 digits of the current word consumed
  } otf_state_t;

  // Decoded digit: at most one flag is set; neither set means zero.
  typedef struct packed {
    logic is_pos;
    logic is_neg;
  } digit_t;

endpackage

// File: rtl/msdf_digit_decode.sv
// Signed-digit decoder: maps the two-bit digit code to {is_pos, is_neg}.
// The redundant code 2'b11 is treated as zero, with no error indication.
module msdf_digit_decode
  import msdf_otf_converter_pkg::*;
(
  input  logic [1:0] i_zj,
  output digit_t     o_digit
);

  // Classify the incoming digit code.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_digit = '0;
    case (i_zj)
      DIGIT_POS: o_digit.is_pos = 1'b1;
      DIGIT_NEG: o_digit.is_neg = 1'b1;
      default:   o_digit = '0;  // DIGIT_ZERO and 2'b11 both mean zero
    endcase
  end

endmodule

// File: rtl/msdf_otf_converter.sv
// On-the-fly converter: accepts an MSDF signed-digit stream and assembles one
// (N+1)-bit two's-complement fraction per N digits without any carry-propagate
// adder. Q holds the exact value of the digits so far and QM holds Q minus one
// ulp of the current position, so a negative digit never needs a borrow chain.
module msdf_otf_converter
  import msdf_otf_converter_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active low
  input  logic [1:0]   Zj,
  input  logic         ready_Zj,
  output logic [N:0]   result,
  output logic         result_valid,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [N:0]    r_q;
  logic [N:0]    r_qm;
  logic [CW-1:0] r_cnt;
  otf_state_t    r_state;
  otf_state_t    w_state_next;
  digit_t        w_digit;
  logic [N:0]    w_q_next;
  logic [N:0]    w_qm_next;
  logic          w_last;

  msdf_digit_decode u_decode (
    .i_zj    (Zj),
    .o_digit (w_digit)
  );

  // The N-th digit of a word is the one consumed while the counter is N-1.
  assign w_last = (r_cnt == LAST_CNT);

  // Candidate Q/QM after appending the current digit (select, no add).
  always_comb begin
    w_q_next  = {r_q[N-1:0], 1'b0};
    w_qm_next = {r_qm[N-1:0], 1'b1};
    if (w_digit.is_pos) begin
      w_q_next  = {r_q[N-1:0], 1'b1};
      w_qm_next = {r_q[N-1:0], 1'b0};
    end else if (w_digit.is_neg) begin
      w_q_next  = {r_qm[N-1:0], 1'b1};
      w_qm_next = {r_qm[N-1:0], 1'b0};
    end
  end

  // Next-state logic: any accepted digit enters ACC unless it completes the word.
  always_comb begin
    w_state_next = r_state;
    if (ready_Zj) begin
      w_state_next = w_last ? IDLE : ACC;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_next;
    end
  end

  // Q/QM/counter update and result capture; the word completion re-initialises
  // Q/QM on the same edge so the next digit can start a new word immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q          <= '0;
      r_qm         <= '1;
      r_cnt        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= ready_Zj && w_last;
      if (ready_Zj) begin
        if (w_last) begin
          result <= w_q_next;
          r_q    <= '0;
          r_qm   <= '1;
          r_cnt  <= '0;
        end else begin
          r_q    <= w_q_next;
          r_qm   <= w_qm_next;
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

  // The state flop itself is the busy indication.
  assign busy = (r_state == ACC);

endmodule

// File: tb/tb_msdf_otf_converter.sv
// Bench for msdf_otf_converter: an N=4 instance driven with directed words and
// an N=10 instance driven with random digit streams and random ready gaps.
// Expected words are queued at issue time; per-instance monitors pop and
// compare on every result_valid strobe and check busy/hold every cycle.
module tb_msdf_otf_converter;

  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  zj4, zj10;
  logic        rdy4, rdy10;
  logic [4:0]  res4;
  logic        val4, busy4;
  logic [10:0] res10;
  logic        val10, busy10;

  always #5 clk = ~clk;

  msdf_otf_converter #(.N(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .Zj           (zj4),
    .ready_Zj     (rdy4),
    .result       (res4),
    .result_valid (val4),
    .busy         (busy4)
  );

  msdf_otf_converter #(.N(10)) dut10 (
    .clk          (clk),
    .rst          (rst),
    .Zj           (zj10),
    .ready_Zj     (rdy10),
    .result       (res10),
    .result_valid (val10),
    .busy         (busy10)
  );

  int total = 0;
  int bad   = 0;

  logic [4:0]  exp4_q[$];
  logic [10:0] exp10_q[$];
  int          cnt4 = 0;       // digits of the current word consumed (model)
  int          cnt10 = 0;
  logic [4:0]  held4 = '0;     // last word the DUT should be presenting
  logic [10:0] held10 = '0;
  int          cyc = 0;
  int          strobe4_prev = -1;
  int          strobe4_last = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor for the N=4 instance.
  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst) begin
      held4 = '0;
      check("rst_result4", 64'(res4), 64'd0);
      check("rst_valid4", 64'(val4), 64'd0);
      check("rst_busy4", 64'(busy4), 64'd0);
    end else begin
      check("busy4", 64'(busy4), 64'(cnt4 != 0));
      if (val4) begin
        if (exp4_q.size() == 0) begin
          check("spurious_strobe4", 64'(val4), 64'd0);
        end else begin
          e = exp4_q.pop_front();
          check("result4", 64'(res4), 64'(e));
          held4 = e;
          strobe4_prev = strobe4_last;
          strobe4_last = cyc;
        end
      end else begin
        check("hold4", 64'(res4), 64'(held4));
      end
    end
  end

  // Monitor for the N=10 instance.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst) begin
      held10 = '0;
      check("rst_result10", 64'(res10), 64'd0);
      check("rst_valid10", 64'(val10), 64'd0);
      check("rst_busy10", 64'(busy10), 64'd0);
    end else begin
      check("busy10", 64'(busy10), 64'(cnt10 != 0));
      if (val10) begin
        if (exp10_q.size() == 0) begin
          check("spurious_strobe10", 64'(val10), 64'd0);
        end else begin
          e = exp10_q.pop_front();
          check("result10", 64'(res10), 64'(e));
          held10 = e;
        end
      end else begin
        check("hold10", 64'(res10), 64'(held10));
      end
    end
  end

  // Present one digit (or an idle cycle when r=0) to the N=4 instance.
  task automatic send4(input logic [1:0] d, input bit r);
    zj4  = d;
    rdy4 = r;
    @(posedge clk);
    #1;
    if (r) cnt4 = (cnt4 + 1) % 4;
    rdy4 = 1'b0;
    zj4  = $urandom_range(3);
  endtask

  task automatic send10(input logic [1:0] d, input bit r);
    zj10  = d;
    rdy10 = r;
    @(posedge clk);
    #1;
    if (r) cnt10 = (cnt10 + 1) % 10;
    rdy10 = 1'b0;
    zj10  = $urandom_range(3);
  endtask

  task automatic word4(input logic [1:0] d0, input logic [1:0] d1,
                       input logic [1:0] d2, input logic [1:0] d3);
    send4(d0, 1'b1);
    send4(d1, 1'b1);
    send4(d2, 1'b1);
    send4(d3, 1'b1);
  endtask

  initial begin
    int value;
    int dv;
    logic [1:0] code;
    int wait_cyc;

    rst = 1'b0;
    zj4 = Z; rdy4 = 1'b0;
    zj10 = Z; rdy10 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send4(Z, 1'b0);

    // +1,0,-1,+1 -> 0.4375
    exp4_q.push_back(5'b00111);
    word4(P, Z, M, P);
    send4(Z, 1'b0);
    send4(Z, 1'b0);

    // -1,0,0,0 -> -0.5 ; all -1 -> -1 + 2^-4
    exp4_q.push_back(5'b11000);
    word4(M, Z, Z, Z);
    send4(Z, 1'b0);
    exp4_q.push_back(5'b10001);
    word4(M, M, M, M);
    send4(Z, 1'b0);

    // +1, redundant zero, 3-cycle gap, 0, +1 -> 0.5625
    exp4_q.push_back(5'b01001);
    send4(P, 1'b1);
    send4(X, 1'b1);
    repeat (3) send4($urandom_range(3), 1'b0);
    send4(Z, 1'b1);
    send4(P, 1'b1);
    send4(Z, 1'b0);

    // Back-to-back words: strobes must be exactly 4 cycles apart.
    exp4_q.push_back(5'b01111);
    exp4_q.push_back(5'b11100);
    word4(P, P, P, P);
    word4(M, P, Z, Z);
    send4(Z, 1'b0);
    send4(Z, 1'b0);
    check("strobe_spacing4", 64'(strobe4_last - strobe4_prev), 64'd4);

    // Reset mid-word: the two consumed digits are discarded.
    send4(P, 1'b1);
    send4(P, 1'b1);
    rst  = 1'b0;
    cnt4 = 0;
    cnt10 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    send4(Z, 1'b0);
    exp4_q.push_back(5'b01000);
    word4(P, Z, Z, Z);
    send4(Z, 1'b0);

    // Random N=10 words with random ready gaps.
    for (int w = 0; w < 300; w++) begin
      value = 0;
      for (int i = 1; i <= 10; i++) begin
        case ($urandom_range(3))
          0: begin dv = 1;  code = P; end
          1: begin dv = -1; code = M; end
          2: begin dv = 0;  code = Z; end
          default: begin dv = 0; code = X; end
        endcase
        value += dv * (1 << (10 - i));
        if (i == 10) exp10_q.push_back(11'(value));
        while ($urandom_range(3) == 0) send10($urandom_range(3), 1'b0);
        send10(code, 1'b1);
      end
    end

    // Drain: every queued word must have been presented.
    wait_cyc = 0;
    while ((exp4_q.size() != 0 || exp10_q.size() != 0) && wait_cyc < 30) begin
      @(posedge clk);
      wait_cyc++;
    end
    #1;
    check("drain4", 64'(exp4_q.size()), 64'd0);
    check("drain10", 64'(exp10_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msdf_otf_converter.md
# msdf_otf_converter

Receive end of the MSDF multiplier's serial output: accepts the most-significant-digit-first signed-digit stream (`Zj` qualified by `ready_Zj`), performs on-the-fly conversion to conventional two's-complement, and presents one parallel fixed-point word per N digits. It sits directly downstream of the serial-serial multiplier top and needs no carry-propagate adder. Output is a registered word with a one-cycle valid strobe.

## Interface
- `N`, default 10: digits per result word; matches the multiplier datapath width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `Zj` input 2: signed digit; `Zj[1]` = positive bit, `Zj[0]` = negative bit, digit value = `Zj[1]` − `Zj[0]`.
- `ready_Zj` input 1: `Zj` is valid this cycle; the digit is consumed on this rising edge.
- `result` output N+1: two's-complement fraction, bit N = sign, bits N−1..0 = weights 2^-1..2^-N.
- `result_valid` output 1: one-cycle strobe, `result` is newly updated.
- `busy` output 1: partial word in progress (1..N−1 digits consumed).

## Operation
- Digit decode: 2'b10 → +1, 2'b01 → −1, 2'b00 and 2'b11 → 0 (no error flag).
- Internal registers Q and QM, each N+1 bits, plus a digit counter 0..N−1.
- Word start (counter = 0): Q = 0, QM = all ones (Q − 1 ulp, sign 1).
- Per accepted digit, both registers shift left by one, appending:
  - d = +1: Q ← {Q,1}, QM ← {Q,0}
  - d = 0: Q ← {Q,0}, QM ← {QM,1}
  - d = −1: Q ← {QM,1}, QM ← {QM,0}
- Invariant after j digits: QM = Q − 2^-j, both exact in two's complement.
- FSM: IDLE (counter 0, `busy` 0) → ACC on the first accepted digit → ACC on each subsequent digit → on the N-th digit, load `result` ← final Q, pulse `result_valid`, return to IDLE with Q/QM re-initialised on the same edge.
- `ready_Zj` low: hold all state; gaps of any length allowed mid-word.
- Back-to-back words: a digit arriving in the cycle after the N-th digit starts a new word without bubble.
- Result range: (−1, 1); all −1 digits give −1 + 2^-N, never −1 exactly.

## Timing
- Reset (`rst` low, asynchronous): `result` = 0, `result_valid` = 0, `busy` = 0, counter = 0, Q = 0, QM = all ones; takes effect immediately, including mid-word (partial word discarded).
- Latency: `result` and `result_valid` change on the same edge that consumes the N-th digit; visible the cycle after that digit is presented.
- `result_valid` high for exactly one cycle per word; `result` holds until the next word completes.
- Sustained throughput: one word per N cycles with `ready_Zj` held high.
- `busy` is registered: rises after the first digit edge, falls on the N-th digit edge.

## Structure
- Shared package: digit encoding constants (`DIGIT_POS` 2'b10, `DIGIT_NEG` 2'b01, `DIGIT_ZERO` 2'b00) and the FSM state typedef (IDLE, ACC); the multiplier datapath imports the same encoding constants.
- One combinational sub-module, `msdf_digit_decode`: `Zj` → {is_pos, is_neg}; Q/QM update, counter and FSM in the top module.

## Test plan
- N=4, digits +1,0,−1,+1 with `ready_Zj` continuous → `result` = 5'b00111 (0.4375), `result_valid` one cycle.
- N=4, digits −1,0,0,0 → 5'b11000 (−0.5); digits −1,−1,−1,−1 → 5'b10001 (−0.9375).
- N=4, digits +1,2'b11,0,+1 with `ready_Zj` low 3 cycles between digits 2 and 3 → 5'b01001 (0.5625); `busy` high throughout gap, no spurious strobe.
- N=4, two words back-to-back (+1,+1,+1,+1 then −1,+1,0,0) → 5'b01111 then 5'b11100 on strobes exactly 4 cycles apart.
- Assert `rst` low after 2 digits, release, send +1,0,0,0 → 5'b01000; all outputs 0 during reset, no strobe for the aborted word.
- Default N=10, random digit streams with random `ready_Zj` gaps → `result` equals Σ d_i·2^-i scaled by 2^10, in two's complement, for every word.
